// File: rtl/adc_sample_packer.sv
// adc_sample_packer: decimates the dual-channel ADC sample stream, groups kept
// samples into fixed-length packets and queues them in an output FIFO.
// Optional header word per packet when ADC_PACK_HEADER_EN is defined.
module adc_sample_packer #(
    parameter int unsigned PKT_LEN    = 256,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        enable,
    input  logic [7:0]  decim,
    input  logic        clr_stats,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = 33;
    localparam int unsigned IW = 16;

    typedef enum logic [1:0] {IDLE, DATA, HDR} state_t;

    state_t          state, state_nxt;
    logic [7:0]      dcnt, decim_q;
    logic [IW-1:0]   idx, seq;
    logic [AW:0]     count, wr_ptr, rd_ptr;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic            pend_vld;
    logic [DW-1:0]   pend_word;
    logic [DW-1:0]   head;

    logic            keep_c, full_c, pop_c, last_c;
    logic            wr_req, drop, idx_clr, idx_inc, seq_inc;
    logic [DW-1:0]   wr_word;

    assign keep_c = in_valid && (dcnt == 8'd0) && (state != IDLE);
    // Occupancy counts pending writes, so full is decided before any same-cycle pop.
    assign full_c = (count == (AW+1)'(FIFO_DEPTH));
    assign pop_c  = out_valid && out_ready;
    assign last_c = (idx == IW'(PKT_LEN - 1));

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = out_valid ? head[31:0] : 32'd0;
    assign out_last  = out_valid & head[32];

    // Packet FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Packet FSM next state and write/drop decisions
    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        wr_word   = '0;
        drop      = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    idx_clr = 1'b1;
`ifdef ADC_PACK_HEADER_EN
                    state_nxt = HDR;
`else
                    state_nxt = DATA;
`endif
                end
            end
`ifdef ADC_PACK_HEADER_EN
            HDR: begin
                if (!full_c) begin
                    wr_req    = 1'b1;
                    wr_word   = {1'b0, 16'hA55A, seq};
                    state_nxt = DATA;
                end
            end
`endif
            DATA: begin
                if (keep_c) begin
                    if (full_c) begin
                        drop = 1'b1;
                    end else begin
                        wr_req  = 1'b1;
                        wr_word = {last_c, in_data};
                        if (last_c) begin
                            state_nxt = IDLE;
                            seq_inc   = 1'b1;
                        end else begin
                            idx_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decimation counter; new decim is picked up only at a wrap or while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt    <= 8'd0;
            decim_q <= 8'd0;
        end else if (state == IDLE) begin
            dcnt    <= 8'd0;
            decim_q <= decim;
        end else if (in_valid) begin
            if (dcnt == decim_q) begin
                dcnt    <= 8'd0;
                decim_q <= decim;
            end else begin
                dcnt <= dcnt + 8'd1;
            end
        end
    end

    // Sample index within packet and packet sequence number
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            seq <= '0;
        end else begin
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 16'd1;
            if (seq_inc)      seq <= seq + 16'd1;
        end
    end

    // Overflow statistics; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clr_stats)                  drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (clr_stats) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end
    end

    // FIFO control: write staged one cycle, occupancy reserved at decision time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pend_vld  <= 1'b0;
            pend_word <= '0;
        end else begin
            pend_vld  <= wr_req;
            pend_word <= wr_word;
            if (pend_vld) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_c)    rd_ptr <= rd_ptr + (AW+1)'(1);
            if (wr_req && !pop_c)      count <= count + (AW+1)'(1);
            else if (!wr_req && pop_c) count <= count - (AW+1)'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (pend_vld) mem[wr_ptr[AW-1:0]] <= pend_word;
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: scoreboard bench for adc_sample_packer (default build,
// PKT_LEN=4, FIFO_DEPTH=4).
module tb_adc_sample_packer;

    localparam int unsigned PKT_LEN    = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        enable;
    logic [7:0]  decim;
    logic        clr_stats;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        overflow;
    logic [15:0] drop_count;

    logic [32:0] sb[$];
    int          asrt_cnt = 0;
    int          fail_cnt = 0;

    adc_sample_packer #(.PKT_LEN(PKT_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .enable     (enable),
        .decim      (decim),
        .clr_stats  (clr_stats),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        asrt_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop and compare each word the consumer accepts
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {31'd0, out_last, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] exp_w;
                exp_w = sb.pop_front();
                check("word", {31'd0, out_last, out_data}, {31'd0, exp_w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit push, input bit last);
        if (push) sb.push_back({last, d});
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0;
        decim = 8'd0; clr_stats = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_last",   64'(out_last),   64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;
        tick();

        // Two back-to-back packets, no decimation
        out_ready = 1'b1; enable = 1'b1;
        idle_cycle();
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b1, i == 4);
        idle_cycle();
        for (int i = 5; i <= 8; i++) send(32'(i), 1'b1, i == 8);
        enable = 1'b0;
        wait_drain("t_basic_drain");

        // Decimation by 3: keeps 10,13,16,19; enable drop mid-packet ignored
        decim = 8'd2; enable = 1'b1;
        idle_cycle();
        for (int v = 10; v <= 21; v++) begin
            send(32'(v), (v - 10) % 3 == 0 && v <= 19, v == 19);
            enable = 1'b0;
        end
        decim = 8'd0;
        wait_drain("t_decim_drain");
        check("t_decim_idle", 64'(out_valid), 64'd0);

        // Fill FIFO, then drop two kept samples of the next packet
        out_ready = 1'b0; enable = 1'b1;
        idle_cycle();
        for (int v = 100; v <= 103; v++) send(32'(v), 1'b1, v == 103);
        idle_cycle();
        send(32'd104, 1'b0, 1'b0);
        send(32'd105, 1'b0, 1'b0);
        enable = 1'b0;
        check("t_ovf_flag",  64'(overflow),   64'd1);
        check("t_ovf_count", 64'(drop_count), 64'd2);
        tick();
        check("t_ovf_head",  64'(out_data),   64'd100);
        out_ready = 1'b1;
        wait_drain("t_ovf_release");
        for (int v = 106; v <= 109; v++) send(32'(v), 1'b1, v == 109);
        wait_drain("t_ovf_resume");

        // Clear stats, then drop on full FIFO with same-cycle pop and clear
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t_clr_overflow", 64'(overflow),   64'd0);
        check("t_clr_count",    64'(drop_count), 64'd0);
        out_ready = 1'b0; enable = 1'b1;
        idle_cycle();
        for (int v = 200; v <= 203; v++) send(32'(v), 1'b1, v == 203);
        idle_cycle();
        out_ready = 1'b1; clr_stats = 1'b1;
        send(32'd204, 1'b0, 1'b0);
        clr_stats = 1'b0; enable = 1'b0;
        check("t_fullpop_overflow", 64'(overflow),   64'd1);
        check("t_fullpop_count",    64'(drop_count), 64'd1);
        check("t_fullpop_depth",    64'(sb.size()),  64'd3);
        for (int v = 205; v <= 208; v++) send(32'(v), 1'b1, v == 208);
        wait_drain("t_fullpop_drain");

        // Enable deasserted after the second sample: packet still completes
        enable = 1'b1;
        idle_cycle();
        send(32'd300, 1'b1, 1'b0);
        send(32'd301, 1'b1, 1'b0);
        enable = 1'b0;
        send(32'd302, 1'b1, 1'b0);
        send(32'd303, 1'b1, 1'b1);
        send(32'd304, 1'b0, 1'b0);
        send(32'd305, 1'b0, 1'b0);
        wait_drain("t_endis_drain");
        repeat (3) tick();
        check("t_endis_no_more", 64'(out_valid), 64'd0);

        // Reset mid-packet with three words queued and nonzero stats
        out_ready = 1'b0; enable = 1'b1;
        idle_cycle();
        send(32'd400, 1'b0, 1'b0);
        send(32'd401, 1'b0, 1'b0);
        send(32'd402, 1'b0, 1'b0);
        tick();
        check("t_rst_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("t_rst_valid",    64'(out_valid),  64'd0);
        check("t_rst_data",     64'(out_data),   64'd0);
        check("t_rst_overflow", 64'(overflow),   64'd0);
        check("t_rst_count",    64'(drop_count), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
        send(32'd500, 1'b1, 1'b0);
        check("t_lat_n", 64'(out_valid), 64'd0);
        send(32'd501, 1'b1, 1'b0);
        check("t_lat_n1_valid", 64'(out_valid), 64'd1);
        check("t_lat_n1_data",  64'(out_data),  64'd500);
        send(32'd502, 1'b1, 1'b0);
        send(32'd503, 1'b1, 1'b1);
        enable = 1'b0;
        wait_drain("t_rst_drain");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end

endmodule
